// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch/data) arbiter onto a single fixed-latency memory port
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iReq,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  output logic                  iAck,
  output logic [DATA_WIDTH-1:0] iRdata,
  input  logic                  dReq,
  input  logic                  dWe,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [DATA_WIDTH-1:0] dWdata,
  output logic                  dAck,
  output logic [DATA_WIDTH-1:0] dRdata,
  output logic                  memEn,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_grant;   // 0 = instruction, 1 = data
  logic       grant_data;
  logic       we_q;
  logic       win_data;

  // On a tie the side that did not win last time gets the port.
  assign win_data = dReq && (!iReq || !last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Every access passes through WAIT so memRdata is sampled exactly
  // MEM_LATENCY cycles after memEn, including MEM_LATENCY = 1.
  always_comb begin
    state_nxt = state;
    memEn     = 1'b0;
    memWe     = 1'b0;
    iAck      = 1'b0;
    dAck      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (iReq || dReq) state_nxt = ACCESS;
      end
      ACCESS: begin
        memEn     = 1'b1;
        memWe     = we_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        iAck      = !grant_data;
        dAck      = grant_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      grant_data <= 1'b0;
      we_q       <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      iRdata     <= '0;
      dRdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq || dReq) begin
            grant_data <= win_data;
            last_grant <= win_data;
            memAddr    <= win_data ? dAddr : iAddr;
            we_q       <= win_data && dWe;
            memWdata   <= dWdata;
          end
        end
        ACCESS: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == 4'd0) begin
            // A data write leaves dRdata untouched.
            if (!grant_data)  iRdata <= memRdata;
            else if (!we_q)   dRdata <= memRdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
